// File: rtl/stage5_field_pkg.sv
// Shared constants for the stage-5 field extractors (default substitution value, mux code, offsets).
package stage5_field_pkg;

   localparam int          MAX_MESSAGE_BITS = 512;
   localparam logic [31:0] DEFAULT_INFOR    = 32'hDEAD_BEEF;
   localparam logic [3:0]  MUX_DEFAULT      = 4'hF;

   localparam int MT1_LSB = 0;
   localparam int MT2_LSB = 32;
   localparam int MT3_LSB = 64;

   typedef enum logic [1:0] {
      FLD_MT1,
      FLD_MT2,
      FLD_MT3
   } field_id_e;

   function automatic int default_lsb(input field_id_e id);
      case (id)
         FLD_MT2: default_lsb = MT2_LSB;
         FLD_MT3: default_lsb = MT3_LSB;
         default: default_lsb = MT1_LSB;
      endcase
   endfunction

endpackage

// File: rtl/stage5_field_slice.sv
// One channel's combinational field select: shift the message by lsb, or substitute DEFAULT_INFOR.
module stage5_field_slice
   import stage5_field_pkg::*;
#(
   parameter int MSG_BITS   = MAX_MESSAGE_BITS,
   parameter int FIELD_BITS = 32,
   parameter int CTRL_W     = 4,
   parameter int LSB_W      = 9
) (
   input  logic [MSG_BITS-1:0]   msg,
   input  logic [CTRL_W-1:0]     ctrl,
   input  logic                  en,
   input  logic [LSB_W-1:0]      lsb,
   output logic [FIELD_BITS-1:0] field,
   output logic                  hit
);

   always_comb begin
      hit   = en && (ctrl != CTRL_W'(MUX_DEFAULT));
      field = hit ? FIELD_BITS'(msg >> lsb) : FIELD_BITS'(DEFAULT_INFOR);
   end

endmodule

// File: rtl/stage5_field_extract.sv
// Two-stage elastic field extractor over NUM_CH channels with programmable offset.
// Optional per-channel hit counters are built when STAGE5_STAT_CNT_EN is defined.
module stage5_field_extract
   import stage5_field_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int MSG_BITS   = MAX_MESSAGE_BITS,
   parameter int FIELD_BITS = 32,
   parameter int CTRL_W     = 4,
   parameter int LSB_W      = 9,
   parameter int RST_LSB    = 0,
   parameter int CNT_W      = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         message_en,
   input  logic [NUM_CH*MSG_BITS-1:0]   message,
   input  logic [NUM_CH*CTRL_W-1:0]     message_mux_ctrl,
   input  logic                         cfg_we,
   input  logic [LSB_W-1:0]             cfg_lsb,
   output logic                         cfg_err,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_CH*FIELD_BITS-1:0] field,
   output logic [NUM_CH-1:0]            field_hit,
   output logic [NUM_CH*CNT_W-1:0]      hit_cnt,
   input  logic                         cnt_clr
);

   localparam int MAX_LSB = MSG_BITS - FIELD_BITS;

   logic                         s1_v;
   logic [NUM_CH*MSG_BITS-1:0]   s1_msg;
   logic [NUM_CH*CTRL_W-1:0]     s1_ctrl;
   logic                         s1_en;
   logic [LSB_W-1:0]             s1_lsb;
   logic [LSB_W-1:0]             lsb_reg;
   logic [NUM_CH*FIELD_BITS-1:0] field_nxt;
   logic [NUM_CH-1:0]            hit_nxt;
   logic                         s1_load;
   logic                         s2_load;

   assign in_ready = !s1_v || !out_valid || out_ready;
   assign s1_load  = in_valid && in_ready;
   assign s2_load  = s1_v && (!out_valid || out_ready);

   // S1 captures the beat with the lsb in force at accept time, so later cfg writes never reach it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_msg  <= '0;
         s1_ctrl <= '0;
         s1_en   <= 1'b0;
         s1_lsb  <= '0;
      end else if (s1_load) begin
         s1_v    <= 1'b1;
         s1_msg  <= message;
         s1_ctrl <= message_mux_ctrl;
         s1_en   <= message_en;
         s1_lsb  <= lsb_reg;
      end else if (s2_load) begin
         s1_v    <= 1'b0;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
      stage5_field_slice #(
         .MSG_BITS   (MSG_BITS),
         .FIELD_BITS (FIELD_BITS),
         .CTRL_W     (CTRL_W),
         .LSB_W      (LSB_W)
      ) u_slice (
         .msg   (s1_msg[c*MSG_BITS +: MSG_BITS]),
         .ctrl  (s1_ctrl[c*CTRL_W +: CTRL_W]),
         .en    (s1_en),
         .lsb   (s1_lsb),
         .field (field_nxt[c*FIELD_BITS +: FIELD_BITS]),
         .hit   (hit_nxt[c])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         field     <= {NUM_CH{FIELD_BITS'(DEFAULT_INFOR)}};
         field_hit <= '0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         field     <= field_nxt;
         field_hit <= hit_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // An offset that would run the field past the message end is refused and latched as an error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lsb_reg <= LSB_W'(RST_LSB);
         cfg_err <= 1'b0;
      end else if (cfg_we) begin
         if ({{(32-LSB_W){1'b0}}, cfg_lsb} <= 32'(MAX_LSB)) begin
            lsb_reg <= cfg_lsb;
         end else begin
            cfg_err <= 1'b1;
         end
      end
   end

`ifdef STAGE5_STAT_CNT_EN
   for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (cnt_clr) begin
            cnt <= '0;
         end else if (out_valid && out_ready && field_hit[c] && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign hit_cnt[c*CNT_W +: CNT_W] = cnt;
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_stage5_field_extract.sv
// Scoreboard bench for stage5_field_extract; counter checks run when STAGE5_STAT_CNT_EN is defined.
module tb_stage5_field_extract;
   import stage5_field_pkg::*;

   localparam int NUM_CH     = 3;
   localparam int MSG_BITS   = 512;
   localparam int FIELD_BITS = 32;
   localparam int CTRL_W     = 4;
   localparam int LSB_W      = 9;
   localparam int CNT_W      = 4;
   localparam int MB         = NUM_CH * MSG_BITS;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         in_valid = 1'b0;
   logic                         in_ready;
   logic                         message_en = 1'b0;
   logic [MB-1:0]                message = '0;
   logic [NUM_CH*CTRL_W-1:0]     message_mux_ctrl = '0;
   logic                         cfg_we = 1'b0;
   logic [LSB_W-1:0]             cfg_lsb = '0;
   logic                         cfg_err;
   logic                         out_valid;
   logic                         out_ready = 1'b1;
   logic [NUM_CH*FIELD_BITS-1:0] field;
   logic [NUM_CH-1:0]            field_hit;
   logic [NUM_CH*CNT_W-1:0]      hit_cnt;
   logic                         cnt_clr = 1'b0;

   typedef struct {
      logic [NUM_CH*FIELD_BITS-1:0] field;
      logic [NUM_CH-1:0]            hit;
      int                           acceptCyc;
      bit                           chkLat;
   } beat_t;

   beat_t sb[$];
   beat_t monEntry;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    modelLsb = 0;
   logic [NUM_CH*FIELD_BITS-1:0] allDefault;
   logic [NUM_CH*FIELD_BITS-1:0] heldField;
   logic [NUM_CH-1:0]            heldHit;
   bit    stalled = 0;

   stage5_field_extract #(
      .NUM_CH(NUM_CH), .MSG_BITS(MSG_BITS), .FIELD_BITS(FIELD_BITS), .CTRL_W(CTRL_W),
      .LSB_W(LSB_W), .RST_LSB(0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .message_en(message_en), .message(message), .message_mux_ctrl(message_mux_ctrl),
      .cfg_we(cfg_we), .cfg_lsb(cfg_lsb), .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ready(out_ready), .field(field), .field_hit(field_hit),
      .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [NUM_CH*FIELD_BITS-1:0] expField(input logic [MB-1:0] msg,
                                                            input logic [NUM_CH*CTRL_W-1:0] ctrl,
                                                            input logic en);
      logic [MSG_BITS-1:0]          m;
      logic [NUM_CH*FIELD_BITS-1:0] r;
      for (int c = 0; c < NUM_CH; c++) begin
         m = msg[c*MSG_BITS +: MSG_BITS];
         if (en && ctrl[c*CTRL_W +: CTRL_W] != MUX_DEFAULT)
            r[c*FIELD_BITS +: FIELD_BITS] = m[modelLsb +: FIELD_BITS];
         else
            r[c*FIELD_BITS +: FIELD_BITS] = DEFAULT_INFOR;
      end
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] expHit(input logic [NUM_CH*CTRL_W-1:0] ctrl, input logic en);
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++)
         r[c] = en && (ctrl[c*CTRL_W +: CTRL_W] != MUX_DEFAULT);
      return r;
   endfunction

   function automatic logic [MB-1:0] randMsg(input bit tagLow);
      logic [MB-1:0] r;
      for (int w = 0; w < MB/32; w++)
         r[w*32 +: 32] = $urandom;
      if (tagLow)
         for (int c = 0; c < NUM_CH; c++)
            r[c*MSG_BITS +: 32] = 32'h1000 + c;
      return r;
   endfunction

   // Scoreboard pops on every output handshake and watches held outputs under backpressure.
   always @(negedge clk) begin
      if (!rst) begin
         if (stalled) begin
            checkOutput("stall_valid", 128'(out_valid), 128'(1));
            checkOutput("stall_field", 128'(field), 128'(heldField));
            checkOutput("stall_hit", 128'(field_hit), 128'(heldHit));
         end
         stalled   = out_valid && !out_ready;
         heldField = field;
         heldHit   = field_hit;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_beat", 128'(out_valid), 128'(0));
            end else begin
               monEntry = sb.pop_front();
               checkOutput("field", 128'(field), 128'(monEntry.field));
               checkOutput("field_hit", 128'(field_hit), 128'(monEntry.hit));
               if (monEntry.chkLat)
                  checkOutput("latency", 128'(cyc - monEntry.acceptCyc), 128'(2));
            end
         end
      end else begin
         stalled = 0;
      end
   end

   task automatic applyStimulus(input logic [MB-1:0] msg, input logic [NUM_CH*CTRL_W-1:0] ctrl,
                                input logic en, input bit chkLat);
      beat_t e;
      bit    done = 0;
      message          = msg;
      message_mux_ctrl = ctrl;
      message_en       = en;
      in_valid         = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.field     = expField(msg, ctrl, en);
            e.hit       = expHit(ctrl, en);
            e.acceptCyc = cyc;
            e.chkLat    = chkLat;
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
         if (cfg_we) begin
            if (int'(cfg_lsb) + FIELD_BITS <= MSG_BITS) modelLsb = int'(cfg_lsb);
            cfg_we = 1'b0;
         end
      end
      in_valid = 1'b0;
      if (!done) checkOutput("accept_timeout", 128'(in_ready), 128'(1));
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain", 128'(sb.size()), 128'(0));
   endtask

   task automatic doReset();
      rst = 1'b1;
      sb.delete();
      modelLsb = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) allDefault[c*FIELD_BITS +: FIELD_BITS] = DEFAULT_INFOR;

      doReset();
      @(negedge clk);
      checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
      checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_field", 128'(field), 128'(allDefault));
      checkOutput("rst_field_hit", 128'(field_hit), 128'(0));
      checkOutput("rst_cfg_err", 128'(cfg_err), 128'(0));
      checkOutput("rst_hit_cnt", 128'(hit_cnt), 128'(0));
      @(posedge clk);
      #1;

      $display("[TB] back-to-back beats, lsb=0");
      for (int b = 0; b < 3; b++) applyStimulus(randMsg(1), 12'h321, 1'b1, 1'b1);
      waitDrain();

      $display("[TB] default mux control and message_en=0");
      applyStimulus(randMsg(0), 12'h2F1, 1'b1, 1'b0);
      applyStimulus(randMsg(0), 12'h321, 1'b0, 1'b0);
      applyStimulus(randMsg(0), 12'hF7F, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] backpressure");
      fork
         begin
            for (int b = 0; b < 4; b++) applyStimulus(randMsg(0), 12'h456, 1'b1, 1'b0);
         end
         begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            checkOutput("in_ready_stall", 128'(in_ready), 128'(0));
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain();

      $display("[TB] cfg write");
      cfg_lsb = 9'd64;
      cfg_we  = 1'b1;
      applyStimulus(randMsg(0), 12'h123, 1'b1, 1'b0);
      applyStimulus(randMsg(0), 12'h123, 1'b1, 1'b0);
      waitDrain();
      checkOutput("cfg_err_ok", 128'(cfg_err), 128'(0));
      cfg_lsb = 9'(MSG_BITS - 16);
      cfg_we  = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      @(negedge clk);
      checkOutput("cfg_err_set", 128'(cfg_err), 128'(1));
      @(posedge clk);
      #1;
      applyStimulus(randMsg(0), 12'h123, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] reset with beats in flight");
      applyStimulus(randMsg(0), 12'h123, 1'b1, 1'b0);
      applyStimulus(randMsg(0), 12'h123, 1'b1, 1'b0);
      rst = 1'b1;
      sb.delete();
      modelLsb = 0;
      @(negedge clk);
      checkOutput("mid_rst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("mid_rst_field", 128'(field), 128'(allDefault));
      checkOutput("mid_rst_hit", 128'(field_hit), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post_rst_out_valid", 128'(out_valid), 128'(0));
      end
      checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));
      checkOutput("post_rst_cfg_err", 128'(cfg_err), 128'(0));
      @(posedge clk);
      #1;
      applyStimulus(randMsg(1), 12'h321, 1'b1, 1'b1);
      waitDrain();

`ifdef STAGE5_STAT_CNT_EN
      $display("[TB] hit counters");
      doReset();
      for (int b = 0; b < 17; b++) applyStimulus(randMsg(0), 12'h2F1, 1'b1, 1'b0);
      waitDrain();
      checkOutput("cnt_saturate", 128'(hit_cnt), 128'(12'hF0F));
      applyStimulus(randMsg(0), 12'h2F1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("clr_beat_valid", 128'(out_valid), 128'(1));
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      checkOutput("cnt_clr_hit", 128'(hit_cnt), 128'(0));
      @(posedge clk);
      #1;
      applyStimulus(randMsg(0), 12'h2F1, 1'b1, 1'b0);
      waitDrain();
      checkOutput("cnt_after_clr", 128'(hit_cnt), 128'(12'h101));
`else
      checkOutput("hit_cnt_tied", 128'(hit_cnt), 128'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
